dallanma_cozumleyici: RTL and testbench

//  Update-side partner of dallanmaOngorucu. Holds in-flight predictions from fetch in a FIFO.

---
 rtl/dallanma_cozumleyici.sv | 120 ++++++++++++
 tb/tb_dallanma_cozumleyici.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dallanma_cozumleyici.sv
// Branch resolution unit: queues fetch-time predictions, pairs them in order with execute
// results, drives predictor updates and issues redirect/flush on a misprediction.
module dallanma_cozumleyici #(
    parameter int unsigned DERINLIK  = 4,
    parameter int unsigned ADRES_BIT = 32
) (
    input  logic                 clk_g,
    input  logic                 rst_g,
    input  logic                 i_kaydet,
    input  logic [ADRES_BIT-1:0] i_buyruk_adresi,
    input  logic [ADRES_BIT-1:0] i_buyruk,
    input  logic                 i_buyruk_ongoru,
    input  logic [ADRES_BIT-1:0] i_ongoru_adres,
    input  logic                 i_is_comp,
    input  logic                 i_coz_gecerli,
    input  logic                 i_gercek_atladi,
    input  logic [ADRES_BIT-1:0] i_gercek_adres,
    output logic                 o_dolu,
    output logic                 o_bos,
    output logic                 o_guncelle_gecerli,
    output logic [ADRES_BIT-1:0] o_eski_buyruk,
    output logic [ADRES_BIT-1:0] o_eski_buyruk_adresi,
    output logic                 o_buyruk_atladi,
    output logic [ADRES_BIT-1:0] o_atlanan_adres,
    output logic                 o_ongoru_yanlis,
    output logic                 o_yonlendir,
    output logic [ADRES_BIT-1:0] o_yonlendir_adres,
    output logic                 o_hata
);

    localparam int unsigned PW = $clog2(DERINLIK);
    localparam int unsigned CW = PW + 1;

    logic [ADRES_BIT-1:0] pc_mem    [DERINLIK];
    logic [ADRES_BIT-1:0] buyruk_mem[DERINLIK];
    logic [ADRES_BIT-1:0] hedef_mem [DERINLIK];
    logic                 ongoru_mem[DERINLIK];
    logic                 comp_mem  [DERINLIK];

    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;

    logic                 pop, push, yanlis, flush;
    logic [ADRES_BIT-1:0] h_pc, h_buyruk, h_hedef, fall, dogru_adres;
    logic                 h_ongoru, h_comp;

    assign o_dolu = (count_q == CW'(DERINLIK));
    assign o_bos  = (count_q == '0);

    assign h_pc     = pc_mem[rd_q];
    assign h_buyruk = buyruk_mem[rd_q];
    assign h_hedef  = hedef_mem[rd_q];
    assign h_ongoru = ongoru_mem[rd_q];
    assign h_comp   = comp_mem[rd_q];

    assign pop  = i_coz_gecerli & ~o_bos;
    assign fall = h_pc + (h_comp ? ADRES_BIT'(2) : ADRES_BIT'(4));
    assign yanlis = (h_ongoru != i_gercek_atladi)
                  | (h_ongoru & i_gercek_atladi & (h_hedef != i_gercek_adres));
    assign flush = pop & yanlis;
    // A push alongside a mispredicting resolve is younger than the bad branch: drop it.
    assign push  = i_kaydet & (~o_dolu | pop) & ~flush;
    assign dogru_adres = i_gercek_atladi ? i_gercek_adres : fall;

    always_comb begin
        rd_d    = rd_q + PW'(pop);
        wr_d    = wr_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_g) begin
        if (push) begin
            pc_mem[wr_q]     <= i_buyruk_adresi;
            buyruk_mem[wr_q] <= i_buyruk;
            hedef_mem[wr_q]  <= i_ongoru_adres;
            ongoru_mem[wr_q] <= i_buyruk_ongoru;
            comp_mem[wr_q]   <= i_is_comp;
        end
    end

    always_ff @(posedge clk_g) begin
        if (rst_g) begin
            rd_q                 <= '0;
            wr_q                 <= '0;
            count_q              <= '0;
            o_guncelle_gecerli   <= 1'b0;
            o_eski_buyruk        <= '0;
            o_eski_buyruk_adresi <= '0;
            o_buyruk_atladi      <= 1'b0;
            o_atlanan_adres      <= '0;
            o_ongoru_yanlis      <= 1'b0;
            o_yonlendir          <= 1'b0;
            o_yonlendir_adres    <= '0;
            o_hata               <= 1'b0;
        end else begin
            rd_q               <= rd_d;
            wr_q               <= wr_d;
            count_q            <= count_d;
            o_guncelle_gecerli <= pop;
            o_yonlendir        <= flush;
            if (pop) begin
                o_eski_buyruk        <= h_buyruk;
                o_eski_buyruk_adresi <= h_pc;
                o_buyruk_atladi      <= i_gercek_atladi;
                o_atlanan_adres      <= dogru_adres;
                o_ongoru_yanlis      <= yanlis;
                o_yonlendir_adres    <= dogru_adres;
            end
            if (i_coz_gecerli & o_bos) begin
                o_hata <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dallanma_cozumleyici.sv
// Bench for dallanma_cozumleyici: directed scenarios plus random traffic, all checked every
// cycle against a queue-based model of the in-flight branch list.
module tb_dallanma_cozumleyici;

    localparam int D = 4;

    logic        clk_g = 1'b0;
    logic        rst_g, i_kaydet, i_buyruk_ongoru, i_is_comp, i_coz_gecerli, i_gercek_atladi;
    logic [31:0] i_buyruk_adresi, i_buyruk, i_ongoru_adres, i_gercek_adres;
    logic        o_dolu, o_bos, o_guncelle_gecerli, o_buyruk_atladi, o_ongoru_yanlis;
    logic        o_yonlendir, o_hata;
    logic [31:0] o_eski_buyruk, o_eski_buyruk_adresi, o_atlanan_adres, o_yonlendir_adres;

    always #5 clk_g = ~clk_g;

    dallanma_cozumleyici #(.DERINLIK(D), .ADRES_BIT(32)) dut (
        .clk_g(clk_g), .rst_g(rst_g),
        .i_kaydet(i_kaydet), .i_buyruk_adresi(i_buyruk_adresi), .i_buyruk(i_buyruk),
        .i_buyruk_ongoru(i_buyruk_ongoru), .i_ongoru_adres(i_ongoru_adres),
        .i_is_comp(i_is_comp), .i_coz_gecerli(i_coz_gecerli),
        .i_gercek_atladi(i_gercek_atladi), .i_gercek_adres(i_gercek_adres),
        .o_dolu(o_dolu), .o_bos(o_bos), .o_guncelle_gecerli(o_guncelle_gecerli),
        .o_eski_buyruk(o_eski_buyruk), .o_eski_buyruk_adresi(o_eski_buyruk_adresi),
        .o_buyruk_atladi(o_buyruk_atladi), .o_atlanan_adres(o_atlanan_adres),
        .o_ongoru_yanlis(o_ongoru_yanlis), .o_yonlendir(o_yonlendir),
        .o_yonlendir_adres(o_yonlendir_adres), .o_hata(o_hata)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pt;
        logic [31:0] pa;
        logic        cm;
    } ent_t;

    ent_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        e_gv, e_yon, e_atl, e_yan, e_hata;
    logic [31:0] e_eb, e_ea, e_aa, e_ya;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list of in-flight entries; outputs derived straight from the resolve rules.
    task automatic model(input logic k, input logic [31:0] pc, input logic [31:0] ins,
                         input logic pt, input logic [31:0] pa, input logic cm,
                         input logic cz, input logic at, input logic [31:0] aa,
                         input logic r);
        ent_t        h;
        logic        popped, mis;
        logic [31:0] fall, tgt;
        if (r) begin
            q.delete();
            {e_gv, e_yon, e_atl, e_yan, e_hata} = '0;
            {e_eb, e_ea, e_aa, e_ya} = '0;
        end else begin
            e_gv   = 1'b0;
            e_yon  = 1'b0;
            mis    = 1'b0;
            popped = cz && q.size() != 0;
            if (cz && q.size() == 0) e_hata = 1'b1;
            if (popped) begin
                h    = q[0];
                fall = h.pc + (h.cm ? 32'd2 : 32'd4);
                tgt  = at ? aa : fall;
                mis  = (h.pt != at) || (h.pt && at && h.pa != aa);
                e_gv = 1'b1; e_yon = mis; e_yan = mis; e_atl = at;
                e_eb = h.ins; e_ea = h.pc; e_aa = tgt; e_ya = tgt;
            end
            if (mis) q.delete();
            else begin
                if (popped) void'(q.pop_front());
                if (k && (q.size() < D)) q.push_back('{pc, ins, pt, pa, cm});
            end
        end
    endtask

    task automatic compare_all();
        chk("guncelle_gecerli", 32'(o_guncelle_gecerli), 32'(e_gv));
        chk("yonlendir", 32'(o_yonlendir), 32'(e_yon));
        chk("ongoru_yanlis", 32'(o_ongoru_yanlis), 32'(e_yan));
        chk("buyruk_atladi", 32'(o_buyruk_atladi), 32'(e_atl));
        chk("eski_buyruk", o_eski_buyruk, e_eb);
        chk("eski_buyruk_adresi", o_eski_buyruk_adresi, e_ea);
        chk("atlanan_adres", o_atlanan_adres, e_aa);
        chk("yonlendir_adres", o_yonlendir_adres, e_ya);
        chk("hata", 32'(o_hata), 32'(e_hata));
        chk("dolu", 32'(o_dolu), 32'(q.size() == D));
        chk("bos", 32'(o_bos), 32'(q.size() == 0));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then check.
    task automatic step(input logic k, input logic [31:0] pc, input logic pt,
                        input logic [31:0] pa, input logic cm, input logic cz,
                        input logic at, input logic [31:0] aa, input logic r);
        logic [31:0] ins;
        ins = ~pc;
        rst_g = r; i_kaydet = k; i_buyruk_adresi = pc; i_buyruk = ins;
        i_buyruk_ongoru = pt; i_ongoru_adres = pa; i_is_comp = cm;
        i_coz_gecerli = cz; i_gercek_atladi = at; i_gercek_adres = aa;
        model(k, pc, ins, pt, pa, cm, cz, at, aa, r);
        @(negedge clk_g);
        compare_all();
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] pa,
                        input logic cm);
        step(1'b1, pc, pt, pa, cm, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic resolve(input logic at, input logic [31:0] aa);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, at, aa, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic        k, cz, pt, at, cm, r;
        logic [31:0] pc, pa, aa;

        {rst_g, i_kaydet, i_buyruk_ongoru, i_is_comp, i_coz_gecerli, i_gercek_atladi} = '0;
        {i_buyruk_adresi, i_buyruk, i_ongoru_adres, i_gercek_adres} = '0;
        @(negedge clk_g);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("reset_bos", 32'(o_bos), 32'd1);
        chk("reset_dolu", 32'(o_dolu), 32'd0);
        chk("reset_guncelle", 32'(o_guncelle_gecerli), 32'd0);

        // Not-taken predicted and resolved: fall-through +4, no redirect.
        push(32'h10, 1'b0, 32'h0, 1'b0);
        resolve(1'b0, 32'h0);
        chk("t1_guncelle", 32'(o_guncelle_gecerli), 32'd1);
        chk("t1_yanlis", 32'(o_ongoru_yanlis), 32'd0);
        chk("t1_yonlendir", 32'(o_yonlendir), 32'd0);
        chk("t1_atlanan", o_atlanan_adres, 32'h14);

        // Compressed, predicted taken, actually not taken: redirect to +2.
        push(32'h20, 1'b1, 32'h80, 1'b1);
        resolve(1'b0, 32'h0);
        chk("t2_yanlis", 32'(o_ongoru_yanlis), 32'd1);
        chk("t2_yonlendir", 32'(o_yonlendir), 32'd1);
        chk("t2_yon_adres", o_yonlendir_adres, 32'h22);
        chk("t2_bos", 32'(o_bos), 32'd1);

        // Taken both ways but target differs.
        push(32'h30, 1'b1, 32'h80, 1'b0);
        resolve(1'b1, 32'h90);
        chk("t3_yanlis", 32'(o_ongoru_yanlis), 32'd1);
        chk("t3_yon_adres", o_yonlendir_adres, 32'h90);
        chk("t3_atladi", 32'(o_buyruk_atladi), 32'd1);
        idle();
        chk("t3_pulse_gone", 32'(o_yonlendir), 32'd0);

        // Fill, overflow push dropped, drain in order.
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i * 4), 1'b0, 32'h0, 1'b0);
        chk("t4_dolu", 32'(o_dolu), 32'd1);
        push(32'h200, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            resolve(1'b0, 32'h0);
            chk("t4_order", o_eski_buyruk_adresi, 32'h100 + 32'(i * 4));
        end
        chk("t4_bos", 32'(o_bos), 32'd1);

        // Full with push+correct resolve: stays full, write pointer wraps.
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(i * 4), 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_dolu", 32'(o_dolu), 32'd1);
        for (int i = 0; i < 4; i++) resolve(1'b0, 32'h0);
        chk("t6_wrapped_tail", o_eski_buyruk_adresi, 32'h400);
        push(32'h500, 1'b0, 32'h0, 1'b0);
        push(32'h504, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t6_rst_bos", 32'(o_bos), 32'd1);
        chk("t6_rst_pulse", 32'(o_guncelle_gecerli), 32'd0);

        // Three in flight, head mispredicts with same-cycle push: everything flushed.
        for (int i = 0; i < 3; i++) push(32'h600 + 32'(i * 4), 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h44, 1'b0);
        chk("t5_bos", 32'(o_bos), 32'd1);
        chk("t5_yon_adres", o_yonlendir_adres, 32'h44);
        resolve(1'b0, 32'h0);
        chk("t5_hata", 32'(o_hata), 32'd1);
        chk("t5_no_pulse", 32'(o_guncelle_gecerli), 32'd0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            k  = $urandom_range(0, 9) < 6;
            cz = $urandom_range(0, 9) < 4;
            pc = $urandom & 32'hffff_fffe;
            pt = 1'($urandom);
            cm = 1'($urandom);
            pa = $urandom_range(0, 1) != 0 ? 32'h80 : 32'h90;
            at = 1'($urandom);
            if (q.size() != 0 && $urandom_range(0, 1) != 0) aa = q[0].pa;
            else aa = $urandom_range(0, 1) != 0 ? 32'h80 : 32'h90;
            r  = $urandom_range(0, 199) == 0;
            step(k, pc, pt, pa, cm, cz, at, aa, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
